tx_serializer: RTL

TX_SERIALIZER -- requirements
Module: tx_serializer

---
 rtl/serdes_tx_pkg.sv | 25 ++
 rtl/prbs7_gen.sv | 42 ++++
 rtl/tx_serializer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/serdes_tx_pkg.sv
// ============================================================================
// serdes_tx_pkg : shared types and constants for the serial transmit path
// Rev 1.0
// ============================================================================
`default_nettype none

package serdes_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PRBS = 2'd2
  } tx_state_e;

  localparam int         DEFAULT_DATA_WIDTH = 10;

  // x^7 + x^6 + 1: feedback from the two most significant register stages
  localparam int         PRBS7_LEN    = 7;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;
  localparam logic [6:0] PRBS7_PERIOD = 7'd127;

endpackage

`default_nettype wire

// File: rtl/prbs7_gen.sv
// ============================================================================
// prbs7_gen : Fibonacci PRBS7 generator, MSB-out, seed reload on demand
// Rev 1.0
// ============================================================================
`default_nettype none

module prbs7_gen
  import serdes_tx_pkg::*;
(
  input  logic                 CLK,
  input  logic                 Rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [PRBS7_LEN-1:0] seed,
  output logic                 bit_out
);

  logic [PRBS7_LEN-1:0] lfsr_q;
  logic [PRBS7_LEN-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (en) begin
      lfsr_d = {lfsr_q[PRBS7_LEN-2:0], lfsr_q[PRBS7_TAP_HI] ^ lfsr_q[PRBS7_TAP_LO]};
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[PRBS7_LEN-1];

endmodule

`default_nettype wire

// File: rtl/tx_serializer.sv
// ============================================================================
// tx_serializer : LSB-first symbol serializer with hold buffer and PRBS7 mode
// Rev 1.0
// ============================================================================
`default_nettype none

module tx_serializer
  import serdes_tx_pkg::*;
#(
  parameter int         DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [6:0] PRBS_SEED  = 7'h7F
) (
  input  logic                  CLK,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Data_valid,
  output logic                  Data_ready,
  input  logic                  Prbs_en,
  input  logic                  Uf_clr,
  output logic                  Data_out,
  output logic                  Sym_start,
  output logic                  Underflow
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  tx_state_e             state_q,      state_d;
  logic [DATA_WIDTH-1:0] hold_q,       hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] shifter_q,    shifter_d;
  logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [6:0]            prbs_cnt_q,   prbs_cnt_d;
  logic                  data_out_q,   data_out_d;
  logic                  sym_start_q,  sym_start_d;
  logic                  underflow_q,  underflow_d;
  logic                  sent_q,       sent_d;
  logic                  ready_q,      ready_d;

  logic                  do_load;
  logic                  uf_set;
  logic                  prbs_load;
  logic                  prbs_step;
  logic                  prbs_bit;

  prbs7_gen u_prbs (
    .CLK     (CLK),
    .Rst     (Rst),
    .load    (prbs_load),
    .en      (prbs_step),
    .seed    (PRBS_SEED),
    .bit_out (prbs_bit)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shifter_d    = shifter_q;
    bit_cnt_d    = bit_cnt_q;
    prbs_cnt_d   = prbs_cnt_q;
    data_out_d   = 1'b0;
    sym_start_d  = 1'b0;
    sent_d       = sent_q;
    do_load      = 1'b0;
    uf_set       = 1'b0;
    prbs_load    = 1'b0;
    prbs_step    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          do_load = 1'b1;
        end else if (Prbs_en) begin
          state_d    = PRBS;
          prbs_load  = 1'b1;
          prbs_cnt_d = 7'd0;
        end
      end
      DATA: begin
        if (bit_cnt_q < CNT_FULL) begin
          data_out_d = shifter_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end else if (hold_valid_q) begin
          do_load = 1'b1;
        end else if (Prbs_en) begin
          state_d    = PRBS;
          prbs_load  = 1'b1;
          prbs_cnt_d = 7'd0;
          bit_cnt_d  = '0;
        end else begin
          state_d   = IDLE;
          uf_set    = sent_q;
          bit_cnt_d = '0;
        end
      end
      PRBS: begin
        // prbs_cnt_q == period means a full 127-bit run has just been sent
        if ((prbs_cnt_q == PRBS7_PERIOD) && !Prbs_en) begin
          if (hold_valid_q) begin
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          data_out_d = prbs_bit;
          prbs_step  = 1'b1;
          prbs_cnt_d = (prbs_cnt_q == PRBS7_PERIOD) ? 7'd1 : prbs_cnt_q + 7'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_load) begin
      state_d      = DATA;
      shifter_d    = hold_q;
      data_out_d   = hold_q[0];
      sym_start_d  = 1'b1;
      bit_cnt_d    = CNT_W'(1);
      hold_valid_d = 1'b0;
      sent_d       = 1'b1;
    end

    // ready_q is low whenever hold is full, so accept never collides with load
    if (Data_valid && ready_q) begin
      hold_d       = Data_in;
      hold_valid_d = 1'b1;
    end

    ready_d     = !hold_valid_d && !Prbs_en;
    underflow_d = uf_set ? 1'b1 : (Uf_clr ? 1'b0 : underflow_q);
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shifter_q    <= '0;
      bit_cnt_q    <= '0;
      prbs_cnt_q   <= 7'd0;
      data_out_q   <= 1'b0;
      sym_start_q  <= 1'b0;
      underflow_q  <= 1'b0;
      sent_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shifter_q    <= shifter_d;
      bit_cnt_q    <= bit_cnt_d;
      prbs_cnt_q   <= prbs_cnt_d;
      data_out_q   <= data_out_d;
      sym_start_q  <= sym_start_d;
      underflow_q  <= underflow_d;
      sent_q       <= sent_d;
      ready_q      <= ready_d;
    end
  end

  assign Data_ready = ready_q;
  assign Data_out   = data_out_q;
  assign Sym_start  = sym_start_q;
  assign Underflow  = underflow_q;

endmodule

`default_nettype wire
